// File: rtl/ram_4port_sched_pkg.sv
// Shared types for the 4-port RAM request scheduler.
// Defines the port count, lane id type and the read-tag bundle.
package ram_4port_sched_pkg;

    localparam int NUM_PORTS = 4;

    // Sized for the largest supported lane count (16), so one
    // package serves every NUM_REQ setting of the scheduler.
    localparam int MAX_REQ = 16;
    localparam int LANE_W  = $clog2(MAX_REQ);

    typedef logic [LANE_W-1:0] lane_id_t;

    typedef struct packed {
        logic     valid;
        lane_id_t lane_id;
    } tag_t;

endpackage

// File: rtl/ram_4port_req_sched_rd_tag_pipe.sv
// Fixed-depth shift register of read tags for one RAM port.
// Ports: clk, rst_n (async low), i_tag in, o_tag = tag DEPTH cycles old.
module rd_tag_pipe
    import ram_4port_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int s = 1; s < DEPTH; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/ram_4port_req_sched.sv
// Round-robin request scheduler in front of a 4-port fixed-latency RAM.
// Ports: per-lane req valid/ready/we/addr/wdata, per-lane read responses,
// and registered port0..3 addr/write_data/en/we plus RAM read data in.
module ram_4port_req_sched
    import ram_4port_sched_pkg::*;
#(
    parameter int NUM_REQ       = 8,
    parameter int MEMORY_DEPTH  = 1024,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
    parameter int DATA_WIDTH    = 32,
    parameter int RD_LATENCY    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   resp_data,
    output logic [ADDRESS_WIDTH-1:0]        port0_addr,
    output logic [DATA_WIDTH-1:0]           port0_write_data,
    output logic                            port0_en,
    output logic                            port0_we,
    input  logic [DATA_WIDTH-1:0]           port0_read_data,
    output logic [ADDRESS_WIDTH-1:0]        port1_addr,
    output logic [DATA_WIDTH-1:0]           port1_write_data,
    output logic                            port1_en,
    output logic                            port1_we,
    input  logic [DATA_WIDTH-1:0]           port1_read_data,
    output logic [ADDRESS_WIDTH-1:0]        port2_addr,
    output logic [DATA_WIDTH-1:0]           port2_write_data,
    output logic                            port2_en,
    output logic                            port2_we,
    input  logic [DATA_WIDTH-1:0]           port2_read_data,
    output logic [ADDRESS_WIDTH-1:0]        port3_addr,
    output logic [DATA_WIDTH-1:0]           port3_write_data,
    output logic                            port3_en,
    output logic                            port3_we,
    input  logic [DATA_WIDTH-1:0]           port3_read_data
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = LANE_W + 1;

    lane_id_t          r_rr_ptr;
    logic [AW-1:0]     r_port_addr [NUM_PORTS];
    logic [DW-1:0]     r_port_data [NUM_PORTS];
    logic              r_port_en   [NUM_PORTS];
    logic              r_port_we   [NUM_PORTS];
    lane_id_t          r_port_lane [NUM_PORTS];
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [NUM_REQ*DW-1:0] r_resp_data;

    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_hit;
    logic [2:0]        w_cnt;
    lane_id_t          w_last;
    lane_id_t          w_next_ptr;
    logic [SW-1:0]     w_sum;
    logic [SW-1:0]     w_inc;
    logic              w_sv;
    logic              w_swe;
    logic              w_cf;
    logic [AW-1:0]     w_sa;
    logic [DW-1:0]     w_sd;
    logic [AW-1:0]     w_s_addr [NUM_PORTS];
    logic [DW-1:0]     w_s_data [NUM_PORTS];
    logic              w_s_we   [NUM_PORTS];
    lane_id_t          w_s_lane [NUM_PORTS];
    logic [DW-1:0]     w_rd     [NUM_PORTS];
    tag_t              w_tag_in [NUM_PORTS];
    tag_t              w_tag_out[NUM_PORTS];

    // Circular scan from r_rr_ptr; slot k collects the k-th grant.
    // A candidate conflicts with earlier grants of this cycle when
    // the addresses match and either side is a write.
    always_comb begin
        w_grant = '0;
        w_cnt   = '0;
        w_last  = '0;
        w_sum   = '0;
        w_hit   = '0;
        w_sv    = 1'b0;
        w_swe   = 1'b0;
        w_cf    = 1'b0;
        w_sa    = '0;
        w_sd    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_s_addr[k] = '0;
            w_s_data[k] = '0;
            w_s_we[k]   = 1'b0;
            w_s_lane[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(j);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            w_hit = '0;
            w_sv  = 1'b0;
            w_swe = 1'b0;
            w_sa  = '0;
            w_sd  = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_sum[LANE_W-1:0] == lane_id_t'(i)) begin
                    w_hit[i] = 1'b1;
                    w_sv     = req_valid[i];
                    w_swe    = req_we[i];
                    w_sa     = req_addr[i*AW +: AW];
                    w_sd     = req_wdata[i*DW +: DW];
                end
            end
            w_cf = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (3'(k) < w_cnt && w_sa == w_s_addr[k]
                    && (w_swe || w_s_we[k])) begin
                    w_cf = 1'b1;
                end
            end
            if (reset && w_sv && !w_cf
                && w_cnt < 3'(NUM_PORTS)) begin
                w_grant = w_grant | w_hit;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (3'(k) == w_cnt) begin
                        w_s_addr[k] = w_sa;
                        w_s_data[k] = w_sd;
                        w_s_we[k]   = w_swe;
                        w_s_lane[k] = w_sum[LANE_W-1:0];
                    end
                end
                w_cnt  = w_cnt + 3'd1;
                w_last = w_sum[LANE_W-1:0];
            end
        end
        w_inc = {1'b0, w_last} + SW'(1);
        if (w_inc >= SW'(NUM_REQ)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_inc[LANE_W-1:0];
        end
    end

    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_port_addr[k] <= '0;
                r_port_data[k] <= '0;
                r_port_en[k]   <= 1'b0;
                r_port_we[k]   <= 1'b0;
                r_port_lane[k] <= '0;
            end
        end else begin
            if (|w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (3'(k) < w_cnt) begin
                    r_port_addr[k] <= w_s_addr[k];
                    r_port_data[k] <= w_s_data[k];
                    r_port_en[k]   <= 1'b1;
                    r_port_we[k]   <= w_s_we[k];
                    r_port_lane[k] <= w_s_lane[k];
                end else begin
                    r_port_en[k] <= 1'b0;
                    r_port_we[k] <= 1'b0;
                end
            end
        end
    end

    assign w_rd[0] = port0_read_data;
    assign w_rd[1] = port1_read_data;
    assign w_rd[2] = port2_read_data;
    assign w_rd[3] = port3_read_data;

    // Tags enter alongside the RAM sampling the port registers, so
    // the tail lines up with the cycle the read data is valid.
    for (genvar gk = 0; gk < NUM_PORTS; gk++) begin : g_tag
        assign w_tag_in[gk] = '{
            valid:   r_port_en[gk] & ~r_port_we[gk],
            lane_id: r_port_lane[gk]
        };
        rd_tag_pipe #(
            .DEPTH(RD_LATENCY)
        ) u_pipe (
            .clk  (clk),
            .rst_n(reset),
            .i_tag(w_tag_in[gk]),
            .o_tag(w_tag_out[gk])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_tag_out[k].valid
                        && w_tag_out[k].lane_id == lane_id_t'(i)) begin
                        r_resp_valid[i]         <= 1'b1;
                        r_resp_data[i*DW +: DW] <= w_rd[k];
                    end
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

    assign port0_addr       = r_port_addr[0];
    assign port0_write_data = r_port_data[0];
    assign port0_en         = r_port_en[0];
    assign port0_we         = r_port_we[0];
    assign port1_addr       = r_port_addr[1];
    assign port1_write_data = r_port_data[1];
    assign port1_en         = r_port_en[1];
    assign port1_we         = r_port_we[1];
    assign port2_addr       = r_port_addr[2];
    assign port2_write_data = r_port_data[2];
    assign port2_en         = r_port_en[2];
    assign port2_we         = r_port_we[2];
    assign port3_addr       = r_port_addr[3];
    assign port3_write_data = r_port_data[3];
    assign port3_en         = r_port_en[3];
    assign port3_we         = r_port_we[3];

endmodule

// File: tb/tb_ram_4port_req_sched.sv
// Directed bench for ram_4port_req_sched with a behavioural 4-port RAM.
// Read responses are scoreboarded by due cycle and lane.
module tb_ram_4port_req_sched;

    localparam int NR  = 8;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, req_we, resp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata, resp_data;
    logic [AW-1:0]    p_addr [4];
    logic [DW-1:0]    p_wd   [4];
    logic [DW-1:0]    p_rd   [4];
    logic             p_en   [4];
    logic             p_we   [4];

    ram_4port_req_sched #(
        .NUM_REQ(NR), .MEMORY_DEPTH(1024), .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .port0_addr(p_addr[0]), .port0_write_data(p_wd[0]),
        .port0_en(p_en[0]), .port0_we(p_we[0]), .port0_read_data(p_rd[0]),
        .port1_addr(p_addr[1]), .port1_write_data(p_wd[1]),
        .port1_en(p_en[1]), .port1_we(p_we[1]), .port1_read_data(p_rd[1]),
        .port2_addr(p_addr[2]), .port2_write_data(p_wd[2]),
        .port2_en(p_en[2]), .port2_we(p_we[2]), .port2_read_data(p_rd[2]),
        .port3_addr(p_addr[3]), .port3_write_data(p_wd[3]),
        .port3_en(p_en[3]), .port3_we(p_we[3]), .port3_read_data(p_rd[3])
    );

    logic [DW-1:0] ram   [1024];
    logic [DW-1:0] rpipe [4][LAT];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (p_en[k] && p_we[k]) ram[p_addr[k]] = p_wd[k];
        for (int k = 0; k < 4; k++) begin
            if (p_en[k] && !p_we[k]) rpipe[k][0] <= ram[p_addr[k]];
            else rpipe[k][0] <= '0;
            for (int s = 1; s < LAT; s++) rpipe[k][s] <= rpipe[k][s-1];
        end
    end

    always_comb
        for (int k = 0; k < 4; k++) p_rd[k] = rpipe[k][LAT-1];

    typedef struct {
        int            due;
        int            lane;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ptr = 0;
    logic [DW-1:0] refm [1024];
    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];
    logic [AW-1:0] e_addr [4];
    logic [DW-1:0] e_wd [4];
    logic          e_en [4];
    logic          e_we [4];
    logic [NR-1:0] last_ready;
    int            gcnt [NR];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ports();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("port%0d_en", k), 64'(p_en[k]), 64'(e_en[k]));
            chk($sformatf("port%0d_we", k), 64'(p_we[k]), 64'(e_we[k]));
            chk($sformatf("port%0d_addr", k), 64'(p_addr[k]),
                64'(e_addr[k]));
            if (e_we[k])
                chk($sformatf("port%0d_wdata", k), 64'(p_wd[k]),
                    64'(e_wd[k]));
        end
    endtask

    task automatic tick();
        int found;
        @(posedge clk);
        #1;
        cyc++;
        chk_ports();
        for (int i = 0; i < NR; i++) begin
            found = -1;
            foreach (sbq[q])
                if (sbq[q].due == cyc && sbq[q].lane == i) found = q;
            chk($sformatf("resp_valid[%0d]", i), 64'(resp_valid[i]),
                64'(found >= 0));
            if (found >= 0) begin
                chk($sformatf("resp_data[%0d]", i),
                    64'(resp_data[i*DW +: DW]), 64'(sbq[found].data));
                sbq.delete(found);
            end
        end
    endtask

    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] we,
                        input logic [NR-1:0] er);
        int k;
        int last;
        int ln;
        k = 0;
        last = -1;
        req_valid = v;
        req_we = we;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_wdata[i*DW +: DW] = d[i];
        end
        #1;
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(er));
        for (int p = 0; p < 4; p++) begin
            e_en[p] = 1'b0;
            e_we[p] = 1'b0;
        end
        for (int j = 0; j < NR; j++) begin
            ln = (ptr + j) % NR;
            if (er[ln] && k < 4) begin
                e_en[k] = 1'b1;
                e_we[k] = we[ln];
                e_addr[k] = a[ln];
                e_wd[k] = d[ln];
                if (we[ln]) refm[a[ln]] = d[ln];
                else sbq.push_back('{cyc + 1 + LAT + 1, ln, refm[a[ln]]});
                k++;
                last = ln;
            end
        end
        if (last >= 0) ptr = (last + 1) % NR;
        tick();
        req_valid = v & ~er;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 32'h1000_0000 + i * 7;
            refm[i] = 32'h1000_0000 + i * 7;
        end
        ram[5] = 32'hDEAD_BEEF;
        refm[5] = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            e_addr[k] = '0;
            e_wd[k] = '0;
            e_en[k] = 1'b0;
            e_we[k] = 1'b0;
            for (int s = 0; s < LAT; s++) rpipe[k][s] = '0;
        end
        for (int i = 0; i < NR; i++) begin
            a[i] = AW'(i);
            d[i] = 32'hA000_0000 + i;
            gcnt[i] = 0;
        end

        req_valid = 8'h01;
        #2;
        chk("ready_in_reset", 64'(req_ready), 64'h0);
        chk("resp_valid_reset", 64'(resp_valid), 64'h0);
        chk("resp_data_reset", 64'(resp_data), 64'h0);
        chk_ports();
        @(posedge clk);
        #1;
        chk("ready_in_reset2", 64'(req_ready), 64'h0);
        req_valid = '0;
        #2 reset = 1'b1;
        tick();

        // six lanes: first four on ports 0..3, rest next cycle
        for (int i = 0; i < NR; i++) a[i] = AW'(20 + i);
        step(8'h3F, 8'h00, 8'h0F);
        step(8'h30, 8'h00, 8'h30);

        // single read of preloaded word
        a[2] = 10'd5;
        step(8'h04, 8'h00, 8'h04);
        repeat (6) step(8'h00, 8'h00, 8'h00);

        // write/read hazard on address 7
        a[0] = 10'd7;
        d[0] = 32'hCAFE_0007;
        a[1] = 10'd7;
        a[2] = 10'd9;
        step(8'h07, 8'h01, 8'h05);
        step(8'h02, 8'h00, 8'h02);

        // read-read same address
        a[3] = 10'd12;
        a[4] = 10'd12;
        step(8'h18, 8'h00, 8'h18);

        // move pointer to lane 0
        a[7] = 10'd30;
        step(8'h80, 8'h00, 8'h80);

        // fairness with all lanes busy
        for (int i = 0; i < NR; i++) a[i] = AW'(40 + i);
        for (int r = 0; r < 4; r++) begin
            step(8'hFF, 8'h00, (r % 2 == 0) ? 8'h0F : 8'hF0);
            for (int i = 0; i < NR; i++) gcnt[i] += int'(last_ready[i]);
        end
        for (int i = 0; i < NR; i++)
            chk($sformatf("fair_cnt[%0d]", i), 64'(gcnt[i]), 64'd2);
        repeat (7) step(8'h00, 8'h00, 8'h00);

        // reset with reads in flight
        a[0] = 10'd50;
        a[1] = 10'd51;
        step(8'h03, 8'h00, 8'h03);
        step(8'h00, 8'h00, 8'h00);
        req_valid = 8'h10;
        #1 reset = 1'b0;
        #1;
        sbq.delete();
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            e_addr[k] = '0;
            e_en[k] = 1'b0;
            e_we[k] = 1'b0;
        end
        chk("ready_mid_reset", 64'(req_ready), 64'h0);
        chk("resp_mid_reset", 64'(resp_valid), 64'h0);
        chk_ports();
        @(posedge clk);
        #1;
        cyc++;
        chk("ready_mid_reset2", 64'(req_ready), 64'h0);
        chk_ports();
        req_valid = '0;
        #2 reset = 1'b1;
        repeat (8) step(8'h00, 8'h00, 8'h00);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
